jtkcpu_regs: RTL and testbench
==============================

Name: jtkcpu_regs

Overview:
Programmer-visible register file of the KCPU core: A, B (D = A:B), X, Y, U, S, DP and CC. It sits immediately downstream of the ALU, committing rslt/rslt_hi/cc_out, and upstream of it, driving opnd0 and cc_in. It also owns TFR/EXG sequencing and indexed-mode pointer post/pre-update.

Parameters:
CC_RST, 8'h50, CC value loaded at reset (F and I set; bit order E,F,H,I,N,Z,V,C).

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active high
cen  in  1  clock enable; no state changes while low
src_sel  in  4  register code driving opnd0
dst_sel  in  4  register code written with rslt when we=1
we  in  1  write rslt to dst_sel
dst2_sel  in  4  register code written with rslt_hi when we2=1 (LMUL/DIVXB)
we2  in  1  write rslt_hi to dst2_sel
rslt  in  16  ALU result
rslt_hi  in  16  ALU high result
cc_we  in  1  load CC from cc_out
cc_out  in  8  ALU flags
xfr_post  in  8  TFR/EXG postbyte; [7:4] source code, [3:0] destination code
tfr_start  in  1  single-cycle transfer request
exg_start  in  1  exchange request
idx_upd  in  1  indexed pointer update strobe
idx_sel  in  2  0 X, 1 Y, 2 U, 3 S
idx_delta  in  16  signed increment applied to the selected pointer
opnd0  out  16  selected register, 8-bit codes zero-extended
cc  out  8  current CC, feeds ALU cc_in
a, b, dp  out  8 each  register values
x, y, u, s  out  16 each  register values
busy  out  1  high while an EXG is in progress

Behaviour:
- Register codes, shared package: 0 A, 1 B, 2 D, 3 X, 4 Y, 5 U, 6 S, 7 DP, 8 CC. Codes 9-15 are invalid: writes are ignored and reads return 0.
- Reset:
  - All registers are 0; CC is CC_RST.
  - busy = 0; FSM state is IDLE.
  - A reset mid-EXG aborts the exchange with no write.
- opnd0 and all register outputs are combinational from the stored values. Writes are visible the cycle after the cen edge.
- Width rules:
  - An 8-bit destination takes the low byte of its source.
  - A 16-bit destination from an 8-bit source gets {8'h00, src}.
  - Writing D sets A=rslt[15:8] and B=rslt[7:0].
  - Writing CC through dst_sel replaces the whole CC.
- Write priority for the same target in one cen cycle, highest first:
  1. rst
  2. EXG commit
  3. we
  4. we2
  5. idx_upd
  6. cc_we
- Targets that do not collide update together. cc_we together with a dst_sel=CC write: the dst_sel write wins.
- idx_upd: ptr <= ptr + idx_delta, modulo 2^16 (wraps 16'hFFFF+1 -> 0). No flags are affected.
- TFR: when tfr_start & cen in IDLE, dst <= src (width rules apply) in one cycle. busy stays 0.
- EXG FSM:
  - IDLE: when exg_start & cen, latch both operands into tmp0/tmp1 and go to SWAP; busy=1.
  - SWAP: on the next cen, write tmp1 to the source and tmp0 to the destination, then return to IDLE; busy=0.
  - Mixed widths: the 8-bit side takes the low byte; the 16-bit side is zero-extended.
  - Source equal to destination: the register is unchanged, but the 2-cycle timing is kept.
  - While busy, we, we2, idx_upd, cc_we, tfr_start and exg_start are ignored.
- cen low: no state changes anywhere, including the FSM.

Decomposition:
- Register codes REG_A..REG_CC and CC_RST join the existing shared include (jtkcpu.inc), next to the CC_x bit indices.
- One natural sub-module, jtkcpu_regmux: a combinational code -> 16-bit read mux, instanced for opnd0 and for both EXG/TFR read ports.

Test Plan:
1. Reset, then read every code -> A=B=DP=0, X=Y=U=S=0, cc=8'h50, busy=0.
2. we, dst=D, rslt=16'h1234; next cycle src=A then src=B -> A=8'h12, B=8'h34, opnd0=16'h0012 then 16'h0034.
3. X=16'hFFFF, idx_upd with idx_sel=0 and delta=+1 -> X=16'h0000; same cycle we to X with rslt=16'h5555 -> X=16'h5555 (we wins).
4. A=8'hAB, Y=16'hCDEF, exg_start with post=8'h04 -> busy high for one cen cycle, then A=8'hEF and Y=16'h00AB; a we during busy is ignored.
5. Start EXG, assert rst during SWAP -> no swap, all registers at reset values, busy=0. Also hold cen=0 for 3 cycles mid-EXG -> state frozen, commit happens on the first cen.
6. LMUL commit: we dst=Y rslt=16'h5678, we2 dst2=X rslt_hi=16'h1234, cc_we cc_out=8'h01 -> X=16'h1234, Y=16'h5678, cc=8'h01.

Source files
------------

// File: rtl/jtkcpu_regs_pkg.sv
// Shared definitions for the KCPU register file: register codes, CC layout,
// register storage struct and the width-aware register write helper.
package jtkcpu_regs_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    // CC bit indices, order E,F,H,I,N,Z,V,C from bit 7 down to bit 0
    localparam int unsigned CC_E = 7;
    localparam int unsigned CC_F = 6;
    localparam int unsigned CC_H = 5;
    localparam int unsigned CC_I = 4;
    localparam int unsigned CC_N = 3;
    localparam int unsigned CC_Z = 2;
    localparam int unsigned CC_V = 1;
    localparam int unsigned CC_C = 0;

    // Default CC after reset: F and I masked
    localparam logic [BYTE_W-1:0] CC_RST_VAL = 8'h50;

    // Programmer-visible register codes
    localparam logic [CODE_W-1:0] REG_A  = 4'd0;
    localparam logic [CODE_W-1:0] REG_B  = 4'd1;
    localparam logic [CODE_W-1:0] REG_D  = 4'd2;
    localparam logic [CODE_W-1:0] REG_X  = 4'd3;
    localparam logic [CODE_W-1:0] REG_Y  = 4'd4;
    localparam logic [CODE_W-1:0] REG_U  = 4'd5;
    localparam logic [CODE_W-1:0] REG_S  = 4'd6;
    localparam logic [CODE_W-1:0] REG_DP = 4'd7;
    localparam logic [CODE_W-1:0] REG_CC = 4'd8;

    typedef enum logic {
        ST_IDLE,
        ST_SWAP
    } exg_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] a;
        logic [BYTE_W-1:0] b;
        logic [BYTE_W-1:0] dp;
        logic [BYTE_W-1:0] cc;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] u;
        logic [DATA_W-1:0] s;
    } regs_t;

    // Write a 16-bit value to a register code; 8-bit targets keep the low byte
    function automatic regs_t reg_write(regs_t r, logic [CODE_W-1:0] code, logic [DATA_W-1:0] v);
        regs_t n;
        n = r;
        case (code)
            REG_A:  n.a  = v[7:0];
            REG_B:  n.b  = v[7:0];
            REG_D:  begin
                n.a = v[15:8];
                n.b = v[7:0];
            end
            REG_X:  n.x  = v;
            REG_Y:  n.y  = v;
            REG_U:  n.u  = v;
            REG_S:  n.s  = v;
            REG_DP: n.dp = v[7:0];
            REG_CC: n.cc = v[7:0];
            default: ;
        endcase
        return n;
    endfunction

    // Map an indexed-mode pointer select (X,Y,U,S) to its register code
    function automatic logic [CODE_W-1:0] idx_code(logic [1:0] sel);
        return REG_X + {2'b00, sel};
    endfunction

endpackage

// File: rtl/jtkcpu_regs_if.sv
// ALU/sequencer-facing bus of the register file.
interface jtkcpu_regs_if;
    import jtkcpu_regs_pkg::*;

    logic [CODE_W-1:0] src_sel;
    logic [CODE_W-1:0] dst_sel;
    logic              we;
    logic [CODE_W-1:0] dst2_sel;
    logic              we2;
    logic [DATA_W-1:0] rslt;
    logic [DATA_W-1:0] rslt_hi;
    logic              cc_we;
    logic [BYTE_W-1:0] cc_out;
    logic [BYTE_W-1:0] xfr_post;
    logic              tfr_start;
    logic              exg_start;
    logic              idx_upd;
    logic [1:0]        idx_sel;
    logic [DATA_W-1:0] idx_delta;

    logic [DATA_W-1:0] opnd0;
    logic [BYTE_W-1:0] cc;
    logic [BYTE_W-1:0] a;
    logic [BYTE_W-1:0] b;
    logic [BYTE_W-1:0] dp;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] u;
    logic [DATA_W-1:0] s;
    logic              busy;

    modport master (
        output src_sel, dst_sel, we, dst2_sel, we2, rslt, rslt_hi, cc_we, cc_out,
               xfr_post, tfr_start, exg_start, idx_upd, idx_sel, idx_delta,
        input  opnd0, cc, a, b, dp, x, y, u, s, busy
    );

    modport slave (
        input  src_sel, dst_sel, we, dst2_sel, we2, rslt, rslt_hi, cc_we, cc_out,
               xfr_post, tfr_start, exg_start, idx_upd, idx_sel, idx_delta,
        output opnd0, cc, a, b, dp, x, y, u, s, busy
    );

endinterface

// File: rtl/jtkcpu_regmux.sv
// Combinational register-code read mux; 8-bit registers are zero-extended.
module jtkcpu_regmux
    import jtkcpu_regs_pkg::*;
(
    input  regs_t             regs_i,
    input  logic [CODE_W-1:0] code_i,
    output logic [DATA_W-1:0] val_o
);

    // Code to value decode, invalid codes read as zero
    always_comb begin
        val_o = '0;
        case (code_i)
            REG_A:  val_o = {8'h00, regs_i.a};
            REG_B:  val_o = {8'h00, regs_i.b};
            REG_D:  val_o = {regs_i.a, regs_i.b};
            REG_X:  val_o = regs_i.x;
            REG_Y:  val_o = regs_i.y;
            REG_U:  val_o = regs_i.u;
            REG_S:  val_o = regs_i.s;
            REG_DP: val_o = {8'h00, regs_i.dp};
            REG_CC: val_o = {8'h00, regs_i.cc};
            default: val_o = '0;
        endcase
    end

endmodule

// File: rtl/jtkcpu_regs.sv
// KCPU programmer-visible register file with TFR/EXG sequencing and
// indexed-mode pointer update.
module jtkcpu_regs
    import jtkcpu_regs_pkg::*;
#(
    parameter logic [7:0] CC_RST = CC_RST_VAL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    jtkcpu_regs_if.slave bus
);

    regs_t             regs_q, regs_d;
    exg_state_e        state_q, state_d;
    logic [DATA_W-1:0] tmp0_q, tmp0_d;
    logic [DATA_W-1:0] tmp1_q, tmp1_d;
    logic [BYTE_W-1:0] post_q, post_d;

    logic [DATA_W-1:0] xfr_src_val;
    logic [DATA_W-1:0] xfr_dst_val;
    logic [DATA_W-1:0] ptr_val;
    logic [DATA_W-1:0] ptr_sum;

    jtkcpu_regmux u_mux_opnd (.regs_i(regs_q), .code_i(bus.src_sel),        .val_o(bus.opnd0));
    jtkcpu_regmux u_mux_xsrc (.regs_i(regs_q), .code_i(bus.xfr_post[7:4]),  .val_o(xfr_src_val));
    jtkcpu_regmux u_mux_xdst (.regs_i(regs_q), .code_i(bus.xfr_post[3:0]),  .val_o(xfr_dst_val));
    jtkcpu_regmux u_mux_ptr  (.regs_i(regs_q), .code_i(idx_code(bus.idx_sel)), .val_o(ptr_val));

    assign ptr_sum = ptr_val + bus.idx_delta;

    // Next-state: writes applied lowest priority first so later ones win
    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        tmp0_d  = tmp0_q;
        tmp1_d  = tmp1_q;
        post_d  = post_q;
        if (cen) begin
            if (state_q == ST_IDLE) begin
                if (bus.cc_we)     regs_d.cc = bus.cc_out;
                if (bus.idx_upd)   regs_d = reg_write(regs_d, idx_code(bus.idx_sel), ptr_sum);
                if (bus.we2)       regs_d = reg_write(regs_d, bus.dst2_sel, bus.rslt_hi);
                if (bus.we)        regs_d = reg_write(regs_d, bus.dst_sel, bus.rslt);
                if (bus.tfr_start) regs_d = reg_write(regs_d, bus.xfr_post[3:0], xfr_src_val);
                if (bus.exg_start) begin
                    tmp0_d  = xfr_src_val;
                    tmp1_d  = xfr_dst_val;
                    post_d  = bus.xfr_post;
                    state_d = ST_SWAP;
                end
            end else begin
                // Source first, destination second: src==dst restores tmp0
                regs_d  = reg_write(regs_d, post_q[7:4], tmp1_q);
                regs_d  = reg_write(regs_d, post_q[3:0], tmp0_q);
                state_d = ST_IDLE;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q  <= '{a: 8'h00, b: 8'h00, dp: 8'h00, cc: CC_RST,
                         x: 16'h0000, y: 16'h0000, u: 16'h0000, s: 16'h0000};
            state_q <= ST_IDLE;
            tmp0_q  <= '0;
            tmp1_q  <= '0;
            post_q  <= '0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            tmp0_q  <= tmp0_d;
            tmp1_q  <= tmp1_d;
            post_q  <= post_d;
        end
    end

    assign bus.a    = regs_q.a;
    assign bus.b    = regs_q.b;
    assign bus.dp   = regs_q.dp;
    assign bus.cc   = regs_q.cc;
    assign bus.x    = regs_q.x;
    assign bus.y    = regs_q.y;
    assign bus.u    = regs_q.u;
    assign bus.s    = regs_q.s;
    assign bus.busy = (state_q == ST_SWAP);

endmodule

// File: tb/tb_jtkcpu_regs.sv
// Self-checking bench for jtkcpu_regs: directed scenarios plus random traffic
// checked every cycle against a claim-based behavioural model.
module tb_jtkcpu_regs;

    logic clk = 1'b0;
    logic rst;
    logic cen;

    jtkcpu_regs_if bus();

    jtkcpu_regs #(.CC_RST(8'h50)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    logic [7:0]  ma, mb, mdp, mcc;
    logic [15:0] mx, my, mu, ms;
    logic        mbusy;
    logic [15:0] mt0, mt1;
    logic [7:0]  mpost;
    logic [7:0]  claim;   // a,b,dp,cc,x,y,u,s already written this cycle

    function automatic logic [15:0] mread(input logic [3:0] c);
        case (c)
            4'd0: return {8'h00, ma};
            4'd1: return {8'h00, mb};
            4'd2: return {ma, mb};
            4'd3: return mx;
            4'd4: return my;
            4'd5: return mu;
            4'd6: return ms;
            4'd7: return {8'h00, mdp};
            4'd8: return {8'h00, mcc};
            default: return 16'h0000;
        endcase
    endfunction

    // A write only lands on physical registers not claimed by a higher-priority source
    task automatic mwr(input logic [3:0] c, input logic [15:0] v);
        case (c)
            4'd0: begin if (!claim[0]) ma = v[7:0]; claim[0] = 1'b1; end
            4'd1: begin if (!claim[1]) mb = v[7:0]; claim[1] = 1'b1; end
            4'd2: begin
                if (!claim[0]) ma = v[15:8];
                if (!claim[1]) mb = v[7:0];
                claim[1:0] = 2'b11;
            end
            4'd3: begin if (!claim[4]) mx = v; claim[4] = 1'b1; end
            4'd4: begin if (!claim[5]) my = v; claim[5] = 1'b1; end
            4'd5: begin if (!claim[6]) mu = v; claim[6] = 1'b1; end
            4'd6: begin if (!claim[7]) ms = v; claim[7] = 1'b1; end
            4'd7: begin if (!claim[2]) mdp = v[7:0]; claim[2] = 1'b1; end
            4'd8: begin if (!claim[3]) mcc = v[7:0]; claim[3] = 1'b1; end
            default: ;
        endcase
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        logic [15:0] sv, dv, iv;
        if (rst) begin
            ma = 0; mb = 0; mdp = 0; mcc = 8'h50;
            mx = 0; my = 0; mu = 0; ms = 0;
            mbusy = 1'b0;
        end else if (cen) begin
            if (mbusy) begin
                claim = 8'h00; mwr(mpost[7:4], mt1);
                claim = 8'h00; mwr(mpost[3:0], mt0);
                mbusy = 1'b0;
            end else begin
                sv = mread(bus.xfr_post[7:4]);
                dv = mread(bus.xfr_post[3:0]);
                iv = mread(4'd3 + {2'b00, bus.idx_sel}) + bus.idx_delta;
                claim = 8'h00;
                if (bus.tfr_start) mwr(bus.xfr_post[3:0], sv);
                if (bus.we)        mwr(bus.dst_sel, bus.rslt);
                if (bus.we2)       mwr(bus.dst2_sel, bus.rslt_hi);
                if (bus.idx_upd)   mwr(4'd3 + {2'b00, bus.idx_sel}, iv);
                if (bus.cc_we)     mwr(4'd8, {8'h00, bus.cc_out});
                if (bus.exg_start) begin
                    mt0 = sv; mt1 = dv; mpost = bus.xfr_post; mbusy = 1'b1;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare every DUT output against the model
    task automatic check_all();
        cmp("a",     {8'h00, bus.a},  {8'h00, ma});
        cmp("b",     {8'h00, bus.b},  {8'h00, mb});
        cmp("dp",    {8'h00, bus.dp}, {8'h00, mdp});
        cmp("cc",    {8'h00, bus.cc}, {8'h00, mcc});
        cmp("x",     bus.x, mx);
        cmp("y",     bus.y, my);
        cmp("u",     bus.u, mu);
        cmp("s",     bus.s, ms);
        cmp("busy",  {15'h0, bus.busy}, {15'h0, mbusy});
        cmp("opnd0", bus.opnd0, mread(bus.src_sel));
    endtask

    task automatic clr();
        bus.src_sel = 0; bus.dst_sel = 0; bus.we = 0; bus.dst2_sel = 0; bus.we2 = 0;
        bus.rslt = 0; bus.rslt_hi = 0; bus.cc_we = 0; bus.cc_out = 0; bus.xfr_post = 0;
        bus.tfr_start = 0; bus.exg_start = 0; bus.idx_upd = 0; bus.idx_sel = 0;
        bus.idx_delta = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [3:0] c, input logic [15:0] v);
        clr(); bus.we = 1; bus.dst_sel = c; bus.rslt = v; step();
    endtask

    initial begin
        clr();
        rst = 1'b1; cen = 1'b1;
        ma = 'x; mb = 'x; mdp = 'x; mcc = 'x; mx = 'x; my = 'x; mu = 'x; ms = 'x;
        mbusy = 0; mt0 = 0; mt1 = 0; mpost = 0; claim = 0;
        step(); step();
        rst = 1'b0;

        // Reset state, every code read back
        cmp("rst_cc", {8'h00, bus.cc}, 16'h0050);
        cmp("rst_busy", {15'h0, bus.busy}, 16'h0000);
        for (int c = 0; c < 16; c++) begin
            clr(); bus.src_sel = 4'(c); #1;
            cmp("rst_read", bus.opnd0, (c == 8) ? 16'h0050 : 16'h0000);
        end

        // D write splits into A:B
        wr(4'd2, 16'h1234);
        clr(); bus.src_sel = 4'd0; #1; cmp("d_to_a", bus.opnd0, 16'h0012);
        bus.src_sel = 4'd1; #1;        cmp("d_to_b", bus.opnd0, 16'h0034);

        // Pointer wrap, then we beats idx_upd
        wr(4'd3, 16'hFFFF);
        clr(); bus.idx_upd = 1; bus.idx_sel = 0; bus.idx_delta = 16'h0001; step();
        cmp("x_wrap", bus.x, 16'h0000);
        wr(4'd3, 16'hFFFF);
        clr(); bus.idx_upd = 1; bus.idx_delta = 16'h0001;
        bus.we = 1; bus.dst_sel = 4'd3; bus.rslt = 16'h5555; step();
        cmp("x_we_wins", bus.x, 16'h5555);

        // EXG A,Y with an ignored write while busy
        wr(4'd0, 16'h00AB);
        wr(4'd4, 16'hCDEF);
        clr(); bus.exg_start = 1; bus.xfr_post = 8'h04; step();
        cmp("exg_busy", {15'h0, bus.busy}, 16'h0001);
        clr(); bus.we = 1; bus.dst_sel = 4'd0; bus.rslt = 16'h0011; step();
        cmp("exg_busy_done", {15'h0, bus.busy}, 16'h0000);
        cmp("exg_a", {8'h00, bus.a}, 16'h00EF);
        cmp("exg_y", bus.y, 16'h00AB);

        // Reset during SWAP aborts the exchange
        clr(); bus.exg_start = 1; bus.xfr_post = 8'h04; step();
        clr(); rst = 1'b1; step(); rst = 1'b0;
        cmp("abort_a", {8'h00, bus.a}, 16'h0000);
        cmp("abort_y", bus.y, 16'h0000);
        cmp("abort_busy", {15'h0, bus.busy}, 16'h0000);

        // cen low freezes a pending EXG
        wr(4'd0, 16'h0012);
        wr(4'd3, 16'h3456);
        clr(); bus.exg_start = 1; bus.xfr_post = 8'h03; step();
        clr(); cen = 1'b0; step(); step(); step();
        cmp("frz_busy", {15'h0, bus.busy}, 16'h0001);
        cmp("frz_a", {8'h00, bus.a}, 16'h0012);
        cen = 1'b1; step();
        cmp("frz_a_done", {8'h00, bus.a}, 16'h0056);
        cmp("frz_x_done", bus.x, 16'h0012);

        // LMUL-style triple commit
        clr(); bus.we = 1; bus.dst_sel = 4'd4; bus.rslt = 16'h5678;
        bus.we2 = 1; bus.dst2_sel = 4'd3; bus.rslt_hi = 16'h1234;
        bus.cc_we = 1; bus.cc_out = 8'h01; step();
        cmp("lmul_x", bus.x, 16'h1234);
        cmp("lmul_y", bus.y, 16'h5678);
        cmp("lmul_cc", {8'h00, bus.cc}, 16'h0001);

        // TFR A -> X zero-extends
        clr(); bus.tfr_start = 1; bus.xfr_post = 8'h03; step();
        cmp("tfr_x", bus.x, 16'h0056);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            cen = ($urandom_range(0, 4) != 0);
            bus.src_sel   = 4'($urandom_range(0, 15));
            bus.dst_sel   = 4'($urandom_range(0, 10));
            bus.dst2_sel  = 4'($urandom_range(0, 10));
            bus.we        = ($urandom_range(0, 2) == 0);
            bus.we2       = ($urandom_range(0, 3) == 0);
            bus.rslt      = 16'($urandom);
            bus.rslt_hi   = 16'($urandom);
            bus.cc_we     = ($urandom_range(0, 3) == 0);
            bus.cc_out    = 8'($urandom);
            bus.xfr_post  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            bus.exg_start = ($urandom_range(0, 7) == 0);
            bus.tfr_start = !bus.exg_start && ($urandom_range(0, 7) == 0);
            bus.idx_upd   = ($urandom_range(0, 2) == 0);
            bus.idx_sel   = 2'($urandom_range(0, 3));
            bus.idx_delta = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed(5'($urandom_range(0, 31))));
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
